led_blink_monitor: RTL and testbench
====================================

LED_BLINK_MONITOR -- requirements
Module: led_blink_monitor

Interface
REQ-001 Parameter CNT_W, default 24: width of the run-length counter and of meas_cycles.
REQ-002 Parameter HALF_PERIOD, default 5000000: expected cycles per LED level.
REQ-003 Parameter TOL, default 2: allowed deviation (cycles) from HALF_PERIOD.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 Port: clk  in  1  system clock; all logic on its rising edge.
REQ-006 Port: rst  in  1  synchronous reset, active-high.
REQ-007 Port: led  in  1  LED level from the upstream LChika_m instance, synchronous to clk.
REQ-008 Port: meas_valid  out  1  a completed level measurement is held on the meas_* outputs.
REQ-009 Port: meas_ready  in  1  consumer accepts; a transfer occurs when meas_valid && meas_ready.
REQ-010 Port: meas_level  out  1  the LED level that was measured (1 = led high).
REQ-011 Port: meas_cycles  out  CNT_W  duration of that level in clk cycles, saturating.
REQ-012 Port: meas_err  out  1  meas_cycles lies outside [HALF_PERIOD-TOL, HALF_PERIOD+TOL].
REQ-013 Port: err_count  out  8  number of measurements with meas_err set, saturating at 255.
REQ-014 Port: overrun  out  1  sticky flag: a measurement was dropped because the output slot was full.

Function
REQ-015 The monitor SHALL register led once (led_q) and SHALL define an edge as led != led_q.
REQ-016 FSM states SHALL be SYNC, which waits for the first edge after reset, and RUN, which counts levels.
REQ-017 In SYNC: no measurement, counter held at 0; on the first edge the FSM enters RUN and sets the counter to 1.
REQ-018 The first partial level after reset SHALL never be reported.
REQ-019 In RUN: each cycle without an edge, the counter increments by 1 and saturates at 2^CNT_W-1.
REQ-020 In RUN, on an edge: the counter value and led_q are offered as a measurement, and the counter reloads to 1 in the same cycle.
REQ-021 Latency: meas_valid SHALL rise on the cycle after the edge cycle.
REQ-022 The output slot SHALL be one entry; meas_* SHALL be stable while meas_valid is high and not yet accepted.
REQ-023 A measurement SHALL load the slot if the slot is empty or is being accepted in the same cycle.
REQ-024 If the slot is full and not being accepted, the measurement SHALL be dropped, overrun SHALL set, and the slot SHALL keep its contents.
REQ-025 meas_valid SHALL clear after acceptance unless a new measurement loads in the same cycle.
REQ-026 meas_err SHALL be computed at load time with unsigned comparison; a saturated count SHALL always set meas_err.
REQ-027 If HALF_PERIOD < TOL, the lower bound SHALL clamp to 0.
REQ-028 err_count SHALL increment when a loaded measurement has meas_err=1; dropped measurements SHALL not count.
REQ-029 overrun SHALL stay set until reset.

Reset
REQ-030 On rst=1 at a clock edge, the monitor SHALL set: FSM to SYNC, counter to 0, and led_q to the current led value.
REQ-031 On rst=1 at a clock edge, the outputs SHALL reset to: meas_valid=0, meas_level=0, meas_cycles=0, meas_err=0, err_count=0, overrun=0.
REQ-032 Reset asserted mid-measurement or while meas_valid=1 SHALL discard all pending data, with no transfer in that cycle.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (SYNC, RUN) and the default HALF_PERIOD/TOL constants, so they match LChika_m's divider constant.
REQ-034 One sub-module, led_edge_detect, SHALL contain led_q and the edge pulse; the counter, FSM and slot SHALL stay in led_blink_monitor.

Verification
REQ-035 Scenario 1: HALF_PERIOD=8, TOL=0; led toggles every 8 cycles; meas_ready=1 -> measurements (level,cycles) alternate (1,8),(0,8); meas_err=0 throughout; err_count=0.
REQ-036 Scenario 2: led held high from reset, first edge at cycle 3 -> no measurement for the partial level; the first report is the following full level.
REQ-037 Scenario 3: HALF_PERIOD=8, TOL=1; levels of 6, 7, 9 and 10 cycles -> meas_err = 1, 0, 0, 1 respectively; err_count=2.
REQ-038 Scenario 4: meas_ready=0 across two edges -> first measurement held unchanged, second dropped, overrun=1; after meas_ready=1 for one cycle, meas_valid falls.
REQ-039 Scenario 5: CNT_W=4, led static for 40 cycles then an edge -> meas_cycles=15 and meas_err=1.
REQ-040 Scenario 6: rst pulsed while meas_valid=1 and the counter is at 5 -> all outputs return to reset values the next cycle, and the FSM returns to SYNC.

Source files
------------

// File: rtl/led_blink_monitor_pkg.sv
// Shared types and defaults for the LED blink monitor; defaults track the
// LChika_m divider so a monitor dropped next to it needs no overrides.
package led_blink_monitor_pkg;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } mon_state_t;

    localparam int unsigned DEF_HALF_PERIOD = 5000000;
    localparam int unsigned DEF_TOL         = 2;
    localparam int unsigned ERR_CNT_W       = 8;
    localparam int unsigned BOUND_W         = 64;

    // Lower acceptance bound, clamped at zero when the tolerance exceeds the period.
    function automatic logic [BOUND_W-1:0] lower_bound(input logic [BOUND_W-1:0] half_period,
                                                       input logic [BOUND_W-1:0] tol);
        if (half_period < tol) begin
            return '0;
        end
        return half_period - tol;
    endfunction

endpackage

// File: rtl/led_blink_monitor_edge_detect.sv
// Registers the LED level once and flags a level change against that copy.
module led_edge_detect (
    input  logic clk,
    input  logic led,
    output logic led_q,
    output logic edge_c
);

    // Reset would load the live level too, so no reset branch is needed here.
    always_ff @(posedge clk) begin
        led_q <= led;
    end

    assign edge_c = led != led_q;

endmodule

// File: rtl/led_blink_monitor.sv
// Measures each LED level's duration, flags out-of-tolerance levels and
// offers them through a single-entry valid/ready slot.
module led_blink_monitor
    import led_blink_monitor_pkg::*;
#(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int unsigned TOL         = DEF_TOL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 led,
    output logic                 meas_valid,
    input  logic                 meas_ready,
    output logic                 meas_level,
    output logic [CNT_W-1:0]     meas_cycles,
    output logic                 meas_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 overrun
);

    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [BOUND_W-1:0] LO_BOUND = lower_bound(BOUND_W'(HALF_PERIOD), BOUND_W'(TOL));
    localparam logic [BOUND_W-1:0] HI_BOUND = BOUND_W'(HALF_PERIOD) + BOUND_W'(TOL);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic             led_q;
    logic             edge_c;
    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             offer_c;
    logic             take_c;
    logic             load_c;
    logic             drop_c;
    logic             cnt_err_c;

    led_edge_detect u_edge (
        .clk    (clk),
        .led    (led),
        .led_q  (led_q),
        .edge_c (edge_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // SYNC discards the partial level seen after reset; RUN measures full levels.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        offer_c = 1'b0;
        case (state_q)
            SYNC: begin
                cnt_d = '0;
                if (edge_c) begin
                    state_d = RUN;
                    cnt_d   = CNT_W'(1);
                end
            end
            RUN: begin
                if (edge_c) begin
                    offer_c = 1'b1;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = SYNC;
                cnt_d   = '0;
            end
        endcase
    end

    assign take_c    = meas_valid && meas_ready;
    assign load_c    = offer_c && (!meas_valid || take_c);
    assign drop_c    = offer_c && meas_valid && !meas_ready;
    assign cnt_err_c = (cnt_q == CNT_MAX)
                    || (BOUND_W'(cnt_q) < LO_BOUND)
                    || (BOUND_W'(cnt_q) > HI_BOUND);

    // One-entry output slot; contents frozen until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            meas_valid  <= 1'b0;
            meas_level  <= 1'b0;
            meas_cycles <= '0;
            meas_err    <= 1'b0;
            err_count   <= '0;
            overrun     <= 1'b0;
        end else begin
            if (load_c) begin
                meas_valid  <= 1'b1;
                meas_level  <= led_q;
                meas_cycles <= cnt_q;
                meas_err    <= cnt_err_c;
                if (cnt_err_c && (err_count != ERR_MAX)) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end else if (take_c) begin
                meas_valid <= 1'b0;
            end
            if (drop_c) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_blink_monitor.sv
// Directed bench for led_blink_monitor: three instances share the stimulus,
// each parameterised for the scenarios that target it.
module tb_led_blink_monitor;

    logic        clk;
    logic        rst;
    logic        led;
    logic        meas_ready;

    logic        a_valid, a_level, a_err, a_overrun;
    logic [23:0] a_cycles;
    logic [7:0]  a_err_count;
    logic        b_valid, b_level, b_err, b_overrun;
    logic [23:0] b_cycles;
    logic [7:0]  b_err_count;
    logic        c_valid, c_level, c_err, c_overrun;
    logic [3:0]  c_cycles;
    logic [7:0]  c_err_count;

    int checks = 0;
    int errors = 0;

    led_blink_monitor #(.CNT_W(24), .HALF_PERIOD(8), .TOL(0)) dut_a (
        .clk(clk), .rst(rst), .led(led),
        .meas_valid(a_valid), .meas_ready(meas_ready), .meas_level(a_level),
        .meas_cycles(a_cycles), .meas_err(a_err), .err_count(a_err_count), .overrun(a_overrun)
    );

    led_blink_monitor #(.CNT_W(24), .HALF_PERIOD(8), .TOL(1)) dut_b (
        .clk(clk), .rst(rst), .led(led),
        .meas_valid(b_valid), .meas_ready(meas_ready), .meas_level(b_level),
        .meas_cycles(b_cycles), .meas_err(b_err), .err_count(b_err_count), .overrun(b_overrun)
    );

    led_blink_monitor #(.CNT_W(4), .HALF_PERIOD(8), .TOL(0)) dut_c (
        .clk(clk), .rst(rst), .led(led),
        .meas_valid(c_valid), .meas_ready(meas_ready), .meas_level(c_level),
        .meas_cycles(c_cycles), .meas_err(c_err), .err_count(c_err_count), .overrun(c_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset(input logic lvl);
        rst = 1'b1;
        led = lvl;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", a_valid); end
        checks++; if (a_level !== 1'b0) begin errors++; $display("FAIL reset_level got %0b exp 0", a_level); end
        checks++; if (a_cycles !== 24'd0) begin errors++; $display("FAIL reset_cycles got %0d exp 0", a_cycles); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", a_err); end
        checks++; if (a_err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", a_err_count); end
        checks++; if (a_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b exp 0", a_overrun); end
    endtask

    task automatic test_basic();
        logic v;
        do_reset(1'b0);
        led = 1'b1;
        @(negedge clk);
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL basic_sync_edge valid got %0b exp 0", a_valid); end
        repeat (7) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            v = led;
            led = ~led;
            @(negedge clk);
            checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %0b exp 1", i, a_valid); end
            checks++; if (a_level !== v) begin errors++; $display("FAIL basic_level[%0d] got %0b exp %0b", i, a_level, v); end
            checks++; if (a_cycles !== 24'd8) begin errors++; $display("FAIL basic_cycles[%0d] got %0d exp 8", i, a_cycles); end
            checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL basic_err[%0d] got %0b exp 0", i, a_err); end
            @(negedge clk);
            checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL basic_accept[%0d] valid got %0b exp 0", i, a_valid); end
            repeat (6) @(negedge clk);
        end
        checks++; if (a_err_count !== 8'd0) begin errors++; $display("FAIL basic_err_count got %0d exp 0", a_err_count); end
    endtask

    task automatic test_partial_level();
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        led = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL partial_not_reported valid got %0b exp 0", a_valid); end
        led = 1'b1;
        @(negedge clk);
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL partial_first_valid got %0b exp 1", a_valid); end
        checks++; if (a_level !== 1'b0) begin errors++; $display("FAIL partial_first_level got %0b exp 0", a_level); end
        checks++; if (a_cycles !== 24'd8) begin errors++; $display("FAIL partial_first_cycles got %0d exp 8", a_cycles); end
    endtask

    task automatic test_tolerance();
        int   lens [5] = '{6, 7, 9, 10, 2};
        logic exp_err [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            led = ~led;
            @(negedge clk);
            if (i > 0) begin
                checks++; if (b_valid !== 1'b1) begin errors++; $display("FAIL tol_valid[%0d] got %0b exp 1", i, b_valid); end
                checks++; if (b_cycles !== 24'(lens[i-1])) begin errors++; $display("FAIL tol_cycles[%0d] got %0d exp %0d", i, b_cycles, lens[i-1]); end
                checks++; if (b_err !== exp_err[i-1]) begin errors++; $display("FAIL tol_err[%0d] got %0b exp %0b", i, b_err, exp_err[i-1]); end
            end
            repeat (lens[i] - 1) @(negedge clk);
        end
        checks++; if (b_err_count !== 8'd2) begin errors++; $display("FAIL tol_err_count got %0d exp 2", b_err_count); end
        checks++; if (a_err_count !== 8'd4) begin errors++; $display("FAIL tol_zero_err_count got %0d exp 4", a_err_count); end
    endtask

    task automatic test_overrun();
        do_reset(1'b0);
        led = 1'b1;
        repeat (8) @(negedge clk);
        meas_ready = 1'b0;
        led = 1'b0;
        @(negedge clk);
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got %0b exp 1", a_valid); end
        checks++; if (a_overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %0b exp 0", a_overrun); end
        repeat (4) @(negedge clk);
        led = 1'b1;
        @(negedge clk);
        checks++; if (a_level !== 1'b1) begin errors++; $display("FAIL ovr_held_level got %0b exp 1", a_level); end
        checks++; if (a_cycles !== 24'd8) begin errors++; $display("FAIL ovr_held_cycles got %0d exp 8", a_cycles); end
        checks++; if (a_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b exp 1", a_overrun); end
        checks++; if (a_err_count !== 8'd0) begin errors++; $display("FAIL ovr_drop_not_counted got %0d exp 0", a_err_count); end
        meas_ready = 1'b1;
        @(negedge clk);
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept valid got %0b exp 0", a_valid); end
        checks++; if (a_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0b exp 1", a_overrun); end
    endtask

    task automatic test_saturation();
        do_reset(1'b0);
        led = 1'b1;
        repeat (40) @(negedge clk);
        led = 1'b0;
        @(negedge clk);
        checks++; if (c_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %0b exp 1", c_valid); end
        checks++; if (c_cycles !== 4'd15) begin errors++; $display("FAIL sat_cycles got %0d exp 15", c_cycles); end
        checks++; if (c_err !== 1'b1) begin errors++; $display("FAIL sat_err got %0b exp 1", c_err); end
        checks++; if (a_cycles !== 24'd40) begin errors++; $display("FAIL sat_wide_cycles got %0d exp 40", a_cycles); end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        led = 1'b1;
        repeat (6) @(negedge clk);
        meas_ready = 1'b0;
        led = 1'b0;
        repeat (2) @(negedge clk);
        led = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %0b exp 1", a_valid); end
        checks++; if (a_err_count !== 8'd1) begin errors++; $display("FAIL mid_pre_err_count got %0d exp 1", a_err_count); end
        checks++; if (a_overrun !== 1'b1) begin errors++; $display("FAIL mid_pre_overrun got %0b exp 1", a_overrun); end
        rst = 1'b1;
        meas_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b exp 0", a_valid); end
        checks++; if (a_level !== 1'b0) begin errors++; $display("FAIL mid_level got %0b exp 0", a_level); end
        checks++; if (a_cycles !== 24'd0) begin errors++; $display("FAIL mid_cycles got %0d exp 0", a_cycles); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL mid_err got %0b exp 0", a_err); end
        checks++; if (a_err_count !== 8'd0) begin errors++; $display("FAIL mid_err_count got %0d exp 0", a_err_count); end
        checks++; if (a_overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun got %0b exp 0", a_overrun); end
        led = 1'b0;
        @(negedge clk);
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL mid_resync_valid got %0b exp 0", a_valid); end
        repeat (7) @(negedge clk);
        led = 1'b1;
        @(negedge clk);
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL mid_after_valid got %0b exp 1", a_valid); end
        checks++; if (a_level !== 1'b0) begin errors++; $display("FAIL mid_after_level got %0b exp 0", a_level); end
        checks++; if (a_cycles !== 24'd8) begin errors++; $display("FAIL mid_after_cycles got %0d exp 8", a_cycles); end
    endtask

    initial begin
        rst        = 1'b1;
        led        = 1'b0;
        meas_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_partial_level();
        test_tolerance();
        test_overrun();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
